// File: rtl/cpu_pkg.sv
// Shared processor definitions: fetch sequencer states and datapath widths.
package cpu_pkg;

    localparam int PC_W       = 8;
    localparam int INSTR_W    = 8;
    localparam int IMEM_DEPTH = 8;

    localparam logic [INSTR_W-1:0] DEFAULT_HALT_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, captures instMem output into the IR
// and hands it to decode over a valid/ready handshake.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int                  PC_W        = cpu_pkg::PC_W,
    parameter int                  INSTR_W     = cpu_pkg::INSTR_W,
    parameter int                  IMEM_DEPTH  = cpu_pkg::IMEM_DEPTH,
    parameter logic [PC_W-1:0]     START_ADDR  = '0,
    parameter logic [INSTR_W-1:0]  HALT_OPCODE = cpu_pkg::DEFAULT_HALT_OPCODE
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               start_i,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [INSTR_W-1:0] ir_o,
    output logic [PC_W-1:0]    ir_pc_o,
    output logic               ir_valid_o,
    input  logic               ir_ready_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               halted_o,
    output logic               busy_o
);

    // IMEM_DEPTH is a power of two, so modulo reduces to masking the low bits.
    localparam logic [PC_W-1:0] PC_MASK = PC_W'(IMEM_DEPTH - 1);

    function automatic logic [PC_W-1:0] wrap_pc(input logic [PC_W-1:0] addr);
        return addr & PC_MASK;
    endfunction

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               halted_q, halted_d;

    logic               slot_free;
    logic [PC_W-1:0]    pc_next;

    assign slot_free = !ir_valid_q || ir_ready_i;
    assign pc_next   = wrap_pc(pc_q + PC_W'(1));

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            pc_q       <= START_ADDR;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    pc_d    = START_ADDR;
                end
            end

            FETCH: begin
                // Redirect outranks both fetch and halt detection; any IR in flight is flushed.
                if (redirect_i) begin
                    ir_valid_d = 1'b0;
                    pc_d       = wrap_pc(redirect_pc_i);
                    halted_d   = 1'b0;
                end else if (slot_free) begin
                    if (instr_i == HALT_OPCODE) begin
                        ir_valid_d = 1'b0;
                        state_d    = HALT;
                        halted_d   = 1'b1;
                    end else begin
                        ir_d       = instr_i;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_next;
                    end
                end
            end

            HALT: begin
                if (redirect_i) begin
                    ir_valid_d = 1'b0;
                    pc_d       = wrap_pc(redirect_pc_i);
                    state_d    = FETCH;
                    halted_d   = 1'b0;
                end else if (start_i) begin
                    pc_d     = START_ADDR;
                    state_d  = FETCH;
                    halted_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc_o       = pc_q;
    assign ir_o       = ir_q;
    assign ir_pc_o    = ir_pc_q;
    assign ir_valid_o = ir_valid_q;
    assign halted_o   = halted_q;
    assign busy_o     = (state_q == FETCH);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational instMem model; a second
// instance uses HALT_OPCODE=8'hFF to exercise PC wrap-around.
module tb_fetch_ctrl;

    logic       clk;
    logic       Reset;
    logic       start_i, ir_ready_i, redirect_i;
    logic [7:0] redirect_pc_i;
    logic [7:0] pc_o, instr_i, ir_o, ir_pc_o;
    logic       ir_valid_o, halted_o, busy_o;

    logic       start2;
    logic [7:0] pc2, instr2, ir2, ir_pc2;
    logic       valid2, halted2, busy2;

    logic [7:0] mem [8];
    int total = 0;
    int bad   = 0;

    assign instr_i = mem[pc_o[2:0]];
    assign instr2  = mem[pc2[2:0]];

    fetch_ctrl dut (
        .clk(clk), .Reset(Reset), .start_i(start_i), .pc_o(pc_o), .instr_i(instr_i),
        .ir_o(ir_o), .ir_pc_o(ir_pc_o), .ir_valid_o(ir_valid_o), .ir_ready_i(ir_ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .halted_o(halted_o), .busy_o(busy_o)
    );

    fetch_ctrl #(.HALT_OPCODE(8'hFF)) dut_ff (
        .clk(clk), .Reset(Reset), .start_i(start2), .pc_o(pc2), .instr_i(instr2),
        .ir_o(ir2), .ir_pc_o(ir_pc2), .ir_valid_o(valid2), .ir_ready_i(1'b1),
        .redirect_i(1'b0), .redirect_pc_i(8'h00),
        .halted_o(halted2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        #3;
        tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0; start_i = 0; ir_ready_i = 0; redirect_i = 0; redirect_pc_i = 0; start2 = 0;
        #2;
        total++;
        if ({pc_o, ir_o, ir_pc_o, ir_valid_o, halted_o, busy_o} !== {8'h00, 8'h00, 8'h00, 3'b000}) begin
            bad++;
            $display("FAIL reset: pc=%h ir=%h ir_pc=%h v=%b h=%b b=%b want all zero",
                     pc_o, ir_o, ir_pc_o, ir_valid_o, halted_o, busy_o);
        end
        tick();
        Reset = 1'b1;
        repeat (2) tick();
        total++;
        if (busy_o !== 1'b0 || ir_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b valid=%b want 0 0", busy_o, ir_valid_o);
        end
        $display("reset: done");
    endtask

    task automatic test_stream();
        logic [7:0] exp_ir [6] = '{8'h13, 8'h52, 8'h4b, 8'hc1, 8'h1c, 8'h5d};
        ir_ready_i = 1;
        start_i = 1;
        tick();
        start_i = 0;
        total++;
        if (busy_o !== 1'b1 || ir_valid_o !== 1'b0 || pc_o !== 8'h00) begin
            bad++;
            $display("FAIL stream_start: busy=%b valid=%b pc=%h want 1 0 00", busy_o, ir_valid_o, pc_o);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (ir_valid_o !== 1'b1 || ir_o !== exp_ir[i] || ir_pc_o !== 8'(i)) begin
                bad++;
                $display("FAIL stream[%0d]: v=%b ir=%h pc=%h want 1 %h %h",
                         i, ir_valid_o, ir_o, ir_pc_o, exp_ir[i], 8'(i));
            end
            $display("stream: ir=%h ir_pc=%h", ir_o, ir_pc_o);
        end
        tick();
        total++;
        if (halted_o !== 1'b1 || ir_valid_o !== 1'b0 || pc_o !== 8'h06 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL stream_halt: h=%b v=%b pc=%h b=%b want 1 0 06 0",
                     halted_o, ir_valid_o, pc_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ir_ready_i = 0;
        start_i = 1;
        tick();
        start_i = 0;
        tick();
        total++;
        if (ir_valid_o !== 1'b1 || ir_o !== 8'h13 || pc_o !== 8'h01) begin
            bad++;
            $display("FAIL bp_first: v=%b ir=%h pc=%h want 1 13 01", ir_valid_o, ir_o, pc_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ir_valid_o !== 1'b1 || ir_o !== 8'h13 || ir_pc_o !== 8'h00 || pc_o !== 8'h01) begin
                bad++;
                $display("FAIL bp_hold[%0d]: v=%b ir=%h ir_pc=%h pc=%h want 1 13 00 01",
                         i, ir_valid_o, ir_o, ir_pc_o, pc_o);
            end
        end
        ir_ready_i = 1;
        tick();
        total++;
        if (ir_valid_o !== 1'b1 || ir_o !== 8'h52 || ir_pc_o !== 8'h01) begin
            bad++;
            $display("FAIL bp_release: v=%b ir=%h ir_pc=%h want 1 52 01", ir_valid_o, ir_o, ir_pc_o);
        end
        $display("backpressure: ir=%h ir_pc=%h", ir_o, ir_pc_o);
    endtask

    task automatic test_redirect();
        logic [7:0] targets [2] = '{8'h03, 8'h0B};
        for (int i = 0; i < 2; i++) begin
            redirect_i = 1;
            redirect_pc_i = targets[i];
            tick();
            redirect_i = 0;
            total++;
            if (ir_valid_o !== 1'b0 || pc_o !== 8'h03 || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL redir_flush[%0d]: v=%b pc=%h b=%b want 0 03 1", i, ir_valid_o, pc_o, busy_o);
            end
            tick();
            total++;
            if (ir_valid_o !== 1'b1 || ir_o !== 8'hc1 || ir_pc_o !== 8'h03) begin
                bad++;
                $display("FAIL redir_first[%0d]: v=%b ir=%h ir_pc=%h want 1 c1 03",
                         i, ir_valid_o, ir_o, ir_pc_o);
            end
            $display("redirect to %h: ir=%h ir_pc=%h", targets[i], ir_o, ir_pc_o);
        end
    endtask

    task automatic test_halt_restart();
        repeat (3) tick();
        total++;
        if (halted_o !== 1'b1 || pc_o !== 8'h06) begin
            bad++;
            $display("FAIL hr_halt: h=%b pc=%h want 1 06", halted_o, pc_o);
        end
        // Redirect and start together in HALT: the redirect target must win.
        start_i = 1; redirect_i = 1; redirect_pc_i = 8'h02;
        tick();
        start_i = 0; redirect_i = 0;
        total++;
        if (halted_o !== 1'b0 || busy_o !== 1'b1 || pc_o !== 8'h02 || ir_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL hr_redir_wins: h=%b b=%b pc=%h v=%b want 0 1 02 0",
                     halted_o, busy_o, pc_o, ir_valid_o);
        end
        tick();
        total++;
        if (ir_o !== 8'h4b || ir_pc_o !== 8'h02 || ir_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL hr_redir_data: ir=%h ir_pc=%h v=%b want 4b 02 1", ir_o, ir_pc_o, ir_valid_o);
        end
        repeat (4) tick();
        total++;
        if (halted_o !== 1'b1 || ir_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL hr_halt2: h=%b v=%b want 1 0", halted_o, ir_valid_o);
        end
        start_i = 1;
        tick();
        start_i = 0;
        total++;
        if (halted_o !== 1'b0 || pc_o !== 8'h00 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL hr_restart: h=%b pc=%h b=%b want 0 00 1", halted_o, pc_o, busy_o);
        end
        tick();
        total++;
        if (ir_o !== 8'h13 || ir_pc_o !== 8'h00 || ir_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL hr_restart_data: ir=%h ir_pc=%h v=%b want 13 00 1", ir_o, ir_pc_o, ir_valid_o);
        end
        start_i = 1;
        tick();
        start_i = 0;
        total++;
        if (ir_o !== 8'h52 || ir_pc_o !== 8'h01) begin
            bad++;
            $display("FAIL start_in_fetch: ir=%h ir_pc=%h want 52 01", ir_o, ir_pc_o);
        end
        $display("halt/restart: ir=%h ir_pc=%h", ir_o, ir_pc_o);
    endtask

    task automatic test_idle_redirect();
        do_reset();
        redirect_i = 1; redirect_pc_i = 8'h05;
        tick();
        redirect_i = 0;
        total++;
        if (busy_o !== 1'b0 || pc_o !== 8'h00 || ir_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_redirect: b=%b pc=%h v=%b want 0 00 0", busy_o, pc_o, ir_valid_o);
        end
        $display("idle redirect ignored: pc=%h", pc_o);
    endtask

    task automatic test_ff_wrap();
        start2 = 1;
        tick();
        start2 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (valid2 !== 1'b1 || ir2 !== mem[i % 8] || ir_pc2 !== 8'(i % 8) || halted2 !== 1'b0) begin
                bad++;
                $display("FAIL wrap[%0d]: v=%b ir=%h ir_pc=%h h=%b want 1 %h %h 0",
                         i, valid2, ir2, ir_pc2, halted2, mem[i % 8], 8'(i % 8));
            end
            $display("wrap: ir=%h ir_pc=%h", ir2, ir_pc2);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ir_ready_i = 1;
        start_i = 1;
        tick();
        start_i = 0;
        repeat (2) tick();
        #2;
        Reset = 1'b0;
        #1;
        total++;
        if ({pc_o, ir_o, ir_pc_o, ir_valid_o, halted_o, busy_o} !== {8'h00, 8'h00, 8'h00, 3'b000}) begin
            bad++;
            $display("FAIL async_reset: pc=%h ir=%h ir_pc=%h v=%b h=%b b=%b want all zero",
                     pc_o, ir_o, ir_pc_o, ir_valid_o, halted_o, busy_o);
        end
        tick();
        Reset = 1'b1;
        repeat (3) tick();
        total++;
        if (busy_o !== 1'b0 || ir_valid_o !== 1'b0 || pc_o !== 8'h00) begin
            bad++;
            $display("FAIL post_reset_idle: b=%b v=%b pc=%h want 0 0 00", busy_o, ir_valid_o, pc_o);
        end
        $display("async reset: pc=%h busy=%b", pc_o, busy_o);
    endtask

    initial begin
        mem[0] = 8'h13; mem[1] = 8'h52; mem[2] = 8'h4b; mem[3] = 8'hc1;
        mem[4] = 8'h1c; mem[5] = 8'h5d; mem[6] = 8'h00; mem[7] = 8'h00;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt_restart();
        test_idle_redirect();
        test_ff_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
